mem_arbiter: RTL and testbench

//  Parametrised N-port memory arbiter: lets NUM_PORTS memory masters share one memory port.

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter_rr_picker.sv | 27 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b memory hierarchy, including the arbiter state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Rotating-priority selector: first asserted request at or after rr_ptr, wrapping modulo NUM_PORTS.
module rr_picker #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         valid
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester is the last one written.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr) + k) % NUM_PORTS;
            valid = valid | req[idx];
            grant = req[idx] ? IDX_W'(idx) : grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin arbiter sharing one memory port, with registered grant and a response watchdog.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 m_read,
    input  logic [NUM_PORTS-1:0]                 m_write,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     m_address,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]     m_wdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   m_byte_enable,
    output logic [NUM_PORTS-1:0]                 m_resp,
    output logic [DATA_W-1:0]                    m_rdata,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_W-1:0]                    mem_address,
    output logic [DATA_W-1:0]                    mem_wdata,
    output logic [DATA_W/8-1:0]                  mem_byte_enable,
    input  logic                                 mem_resp,
    input  logic [DATA_W-1:0]                    mem_rdata,
    output logic                                 busy,
    output logic [$clog2(NUM_PORTS)-1:0]         grant_id,
    output logic                                 err_timeout
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_PORT   = IDX_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    lc3b_arb_state        state;
    lc3b_arb_state        next_state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     pick;
    logic                 pick_valid;
    logic [CNT_W-1:0]     wait_cnt;
    logic [NUM_PORTS-1:0] req;

    assign req = m_read | m_write;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .valid  (pick_valid)
    );

    // Next-state logic: one transaction per BUSY visit, always back through IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    next_state = ARB_BUSY;
                end else begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (mem_resp) begin
                    next_state = ARB_IDLE;
                end else begin
                    next_state = ARB_BUSY;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant capture in IDLE; pointer advances past the winner when its transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if ((state == ARB_IDLE) && pick_valid) begin
            grant_id <= pick;
        end else if ((state == ARB_BUSY) && mem_resp) begin
            rr_ptr <= (grant_id == LAST_PORT) ? '0 : grant_id + IDX_W'(1);
        end
    end

    // Watchdog: saturating BUSY-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ARB_BUSY) begin
                if (wait_cnt != TIMEOUT_CNT) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if ((TIMEOUT != 0) && (state == ARB_BUSY) && (wait_cnt == TIMEOUT_CNT)) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign busy            = (state == ARB_BUSY);
    assign mem_read        = busy & m_read[grant_id];
    assign mem_write       = busy & m_write[grant_id];
    assign mem_address     = busy ? m_address[grant_id]     : '0;
    assign mem_wdata       = busy ? m_wdata[grant_id]       : '0;
    assign mem_byte_enable = busy ? m_byte_enable[grant_id] : '0;
    assign m_resp          = (busy & mem_resp) ? (NUM_PORTS'(1) << grant_id) : '0;
    assign m_rdata         = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a 2-port arbiter with an 8-cycle watchdog and a 4-port one with the watchdog disabled.
module tb_mem_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [1:0]        a_read, a_write, a_resp, a_mbe;
    logic [1:0][15:0]  a_addr, a_wdata;
    logic [1:0][1:0]   a_be;
    lc3b_word          a_rdata, a_mrdata, a_maddr, a_mwdata;
    logic              a_mread, a_mwrite, a_mresp, a_busy, a_err;
    logic [0:0]        a_gid;

    logic [3:0]        b_read, b_write, b_resp;
    logic [3:0][15:0]  b_addr, b_wdata;
    logic [3:0][1:0]   b_be;
    lc3b_word          b_rdata, b_mrdata, b_maddr, b_mwdata;
    lc3b_mem_wmask     b_mbe;
    logic              b_mread, b_mwrite, b_mresp, b_busy, b_err;
    logic [1:0]        b_gid;

    mem_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .m_read(a_read), .m_write(a_write), .m_address(a_addr), .m_wdata(a_wdata),
        .m_byte_enable(a_be), .m_resp(a_resp), .m_rdata(a_rdata),
        .mem_read(a_mread), .mem_write(a_mwrite), .mem_address(a_maddr), .mem_wdata(a_mwdata),
        .mem_byte_enable(a_mbe), .mem_resp(a_mresp), .mem_rdata(a_mrdata),
        .busy(a_busy), .grant_id(a_gid), .err_timeout(a_err)
    );

    mem_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(16), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .m_read(b_read), .m_write(b_write), .m_address(b_addr), .m_wdata(b_wdata),
        .m_byte_enable(b_be), .m_resp(b_resp), .m_rdata(b_rdata),
        .mem_read(b_mread), .mem_write(b_mwrite), .mem_address(b_maddr), .mem_wdata(b_mwdata),
        .mem_byte_enable(b_mbe), .mem_resp(b_mresp), .mem_rdata(b_mrdata),
        .busy(b_busy), .grant_id(b_gid), .err_timeout(b_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_mresp = 1'b0; a_mrdata = '0;
        b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_mresp = 1'b0; b_mrdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic a_serve(input int lat, input logic [15:0] rdata, output bit ok,
                           output logic [0:0] g, output logic [15:0] addr, output logic [1:0] rsp);
        ok = 1'b0; g = '0; addr = '0; rsp = '0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (a_busy) ok = 1'b1;
        end
        if (ok) begin
            g = a_gid;
            addr = a_maddr;
            repeat (lat) @(posedge clk);
            #1;
            a_mresp = 1'b1; a_mrdata = rdata;
            @(negedge clk);
            rsp = a_resp;
            cyc();
            a_mresp = 1'b0; a_mrdata = '0; a_read[g] = 1'b0; a_write[g] = 1'b0;
        end
    endtask

    task automatic b_serve(input int lat, output bit ok,
                           output logic [1:0] g, output logic [15:0] addr, output logic [3:0] rsp);
        ok = 1'b0; g = '0; addr = '0; rsp = '0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (b_busy) ok = 1'b1;
        end
        if (ok) begin
            g = b_gid;
            addr = b_maddr;
            repeat (lat) @(posedge clk);
            #1;
            b_mresp = 1'b1;
            @(negedge clk);
            rsp = b_resp;
            cyc();
            b_mresp = 1'b0; b_read[g] = 1'b0; b_write[g] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({a_busy, a_mread, a_mwrite, a_maddr, a_mwdata, a_mbe, a_resp, a_gid, a_err, a_rdata} !== 56'd0) begin
            failures++;
            $display("FAIL reset_outputs_a: busy=%b rd=%b wr=%b addr=%h resp=%b gid=%b err=%b", a_busy, a_mread,
                     a_mwrite, a_maddr, a_resp, a_gid, a_err);
        end
        checks++;
        if ({b_busy, b_mread, b_mwrite, b_maddr, b_resp, b_gid, b_err} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs_b: busy=%b addr=%h resp=%b gid=%b err=%b", b_busy, b_maddr, b_resp,
                     b_gid, b_err);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        cyc();
        a_addr[0] = 16'h1000;
        a_read[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (a_mread !== 1'b0) begin
            failures++;
            $display("FAIL single_no_same_cycle: mem_read=%b expected 0", a_mread);
        end
        @(negedge clk);
        checks++;
        if ({a_mread, a_busy, a_gid, a_maddr} !== {1'b1, 1'b1, 1'b0, 16'h1000}) begin
            failures++;
            $display("FAIL single_downstream: rd=%b busy=%b gid=%b addr=%h expected 1 1 0 1000", a_mread, a_busy,
                     a_gid, a_maddr);
        end
        cyc();
        cyc();
        a_mresp = 1'b1;
        a_mrdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({a_resp, a_rdata} !== {2'b01, 16'hBEEF}) begin
            failures++;
            $display("FAIL single_resp: m_resp=%b m_rdata=%h expected 01 beef", a_resp, a_rdata);
        end
        cyc();
        a_mresp = 1'b0; a_mrdata = '0; a_read = '0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_resp, a_mread} !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle_after: busy=%b resp=%b rd=%b expected 0", a_busy, a_resp, a_mread);
        end
    endtask

    task automatic test_contention();
        bit          ok;
        logic [0:0]  g;
        logic [15:0] addr;
        logic [1:0]  rsp;
        logic [0:0]  exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        a_addr[0] = 16'h0100;
        a_addr[1] = 16'h0200;
        a_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            a_serve(2, 16'h1234, ok, g, addr, rsp);
            checks++;
            if ({ok, g, addr, rsp} !== {1'b1, exp_g[t], (exp_g[t] ? 16'h0200 : 16'h0100),
                                        (exp_g[t] ? 2'b10 : 2'b01)}) begin
                failures++;
                $display("FAIL contention_%0d: ok=%b gid=%b addr=%h resp=%b expected gid=%b", t, ok, g, addr, rsp,
                         exp_g[t]);
            end
            if (t == 1) a_read = 2'b11;
        end
    endtask

    task automatic test_write();
        bit ok = 1'b0;
        bit p0_resp = 1'b0;
        a_addr[1] = 16'h2002; a_wdata[1] = 16'h00AA; a_be[1] = 2'b01; a_write[1] = 1'b1;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (a_resp[0]) p0_resp = 1'b1;
            if (a_busy) ok = 1'b1;
        end
        checks++;
        if ({ok, a_mwrite, a_mread, a_maddr, a_mwdata, a_mbe, a_gid} !== {3'b110, 16'h2002, 16'h00AA, 2'b01, 1'b1}) begin
            failures++;
            $display("FAIL write_fields: ok=%b wr=%b rd=%b addr=%h wdata=%h be=%b gid=%b", ok, a_mwrite, a_mread,
                     a_maddr, a_mwdata, a_mbe, a_gid);
        end
        cyc();
        a_mresp = 1'b1;
        @(negedge clk);
        checks++;
        if (a_resp !== 2'b10) begin
            failures++;
            $display("FAIL write_resp: m_resp=%b expected 10", a_resp);
        end
        if (a_resp[0]) p0_resp = 1'b1;
        cyc();
        a_mresp = 1'b0; a_write = '0;
        @(negedge clk);
        if (a_resp[0]) p0_resp = 1'b1;
        checks++;
        if ({p0_resp, a_busy} !== 2'b00) begin
            failures++;
            $display("FAIL write_port0_quiet: port0_resp_seen=%b busy=%b expected 0 0", p0_resp, a_busy);
        end
    endtask

    task automatic test_watchdog();
        bit          ok = 1'b0;
        logic [0:0]  g;
        logic [15:0] addr;
        logic [1:0]  rsp;
        do_reset();
        a_addr[0] = 16'h3000;
        a_read[0] = 1'b1;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (a_busy) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({ok, a_err} !== 2'b10) begin
            failures++;
            $display("FAIL watchdog_early: busy_seen=%b err=%b expected 1 0", ok, a_err);
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({a_busy, a_err} !== 2'b11) begin
            failures++;
            $display("FAIL watchdog_set: busy=%b err=%b expected 1 1", a_busy, a_err);
        end
        cyc();
        a_mresp = 1'b1;
        @(negedge clk);
        checks++;
        if (a_resp !== 2'b01) begin
            failures++;
            $display("FAIL watchdog_late_resp: m_resp=%b expected 01", a_resp);
        end
        cyc();
        a_mresp = 1'b0; a_read = '0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_err} !== 2'b01) begin
            failures++;
            $display("FAIL watchdog_sticky: busy=%b err=%b expected 0 1", a_busy, a_err);
        end
        a_read[1] = 1'b1;
        a_serve(1, 16'h0000, ok, g, addr, rsp);
        checks++;
        if ({ok, rsp, a_err} !== 4'b1101) begin
            failures++;
            $display("FAIL watchdog_continue: ok=%b resp=%b err=%b expected 1 10 1", ok, rsp, a_err);
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        logic [0:0]  g;
        logic [15:0] addr;
        logic [1:0]  rsp;
        a_addr[0] = 16'h0100; a_addr[1] = 16'h0200;
        a_read[0] = 1'b1;
        a_serve(1, 16'h0000, ok, g, addr, rsp);
        a_read[1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (a_busy) ok = 1'b1;
        end
        checks++;
        if ({ok, a_gid, a_err} !== 3'b111) begin
            failures++;
            $display("FAIL midrst_pre: busy_seen=%b gid=%b err=%b expected 1 1 1", ok, a_gid, a_err);
        end
        cyc();
        rst_n = 1'b0;
        a_read = '0;
        #1;
        checks++;
        if ({a_busy, a_mread, a_maddr, a_resp, a_gid, a_err} !== 22'd0) begin
            failures++;
            $display("FAIL midrst_outputs: busy=%b rd=%b addr=%h resp=%b gid=%b err=%b expected all 0", a_busy,
                     a_mread, a_maddr, a_resp, a_gid, a_err);
        end
        cyc();
        rst_n = 1'b1;
        a_read = 2'b11;
        a_serve(1, 16'h0000, ok, g, addr, rsp);
        checks++;
        if ({ok, g, rsp} !== 4'b1001) begin
            failures++;
            $display("FAIL midrst_port0_wins: ok=%b gid=%b resp=%b expected 1 0 01", ok, g, rsp);
        end
        a_serve(1, 16'h0000, ok, g, addr, rsp);
        checks++;
        if ({ok, g} !== 2'b11) begin
            failures++;
            $display("FAIL midrst_port1_next: ok=%b gid=%b expected 1 1", ok, g);
        end
    endtask

    task automatic test_fairness();
        bit          ok;
        logic [1:0]  g;
        logic [1:0]  exp_g;
        logic [15:0] addr;
        logic [3:0]  rsp;
        logic [3:0]  exp_r;
        do_reset();
        for (int i = 0; i < 4; i++) b_addr[i] = 16'h4000 + 16'(i);
        b_read = 4'hF;
        for (int t = 0; t < 5; t++) begin
            exp_g = 2'(t % 4);
            exp_r = 4'b0001 << exp_g;
            b_serve((t == 0) ? 20 : 1, ok, g, addr, rsp);
            checks++;
            if ({ok, g, addr, rsp} !== {1'b1, exp_g, 16'h4000 + 16'(exp_g), exp_r}) begin
                failures++;
                $display("FAIL fairness_%0d: ok=%b gid=%0d addr=%h resp=%b expected gid=%0d resp=%b", t, ok, g, addr,
                         rsp, exp_g, exp_r);
            end
            if (t == 0) begin
                checks++;
                if (b_err !== 1'b0) begin
                    failures++;
                    $display("FAIL watchdog_disabled: err=%b expected 0 after 20 busy cycles", b_err);
                end
            end
            if (t < 4) b_read[g] = 1'b1;
            else b_read = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_watchdog();
        test_reset_mid();
        test_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
